// File: rtl/sifive_hart_dcache_req_arbiter.sv
// Round-robin arbiter sharing the hart data-cache request port among NREQ requesters, with ID pool and fence serialization.
// Optional debug scope outputs are enabled by defining SIFIVE_DCACHE_ARB_SCOPE_EN.
module sifive_hart_dcache_req_arbiter #(
  parameter int NREQ  = 2,
  parameter int NSLOT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*32-1:0]  req_addr,
  input  logic [NREQ*4-1:0]   req_wmask,
  input  logic [NREQ*32-1:0]  req_wdata,
  input  logic [NREQ*5-1:0]   req_cmd,
  input  logic [NREQ-1:0]     req_signed,
  input  logic [NREQ*2-1:0]   req_size,
  output logic                cache_req_valid,
  input  logic                cache_req_ready,
  output logic [31:0]         cache_req_addr,
  output logic [3:0]          cache_req_wmask,
  output logic [31:0]         cache_req_wdata,
  output logic [4:0]          cache_req_cmd,
  output logic                cache_req_signed,
  output logic [1:0]          cache_req_size,
  output logic [6:0]          cache_req_id,
  input  logic                cache_resp_valid,
  input  logic [6:0]          cache_resp_id,
  output logic [NREQ-1:0]     resp_valid,
  output logic [6:0]          outstanding,
  output logic                id_err
`ifdef SIFIVE_DCACHE_ARB_SCOPE_EN
  ,
  output logic                scope_valid,
  output logic [31:0]         scope_addr,
  output logic [3:0]          scope_wmask,
  output logic [31:0]         scope_wdata,
  output logic [6:0]          scope_id,
  output logic [4:0]          scope_cmd,
  output logic                scope_signed,
  output logic [1:0]          scope_size
`endif
);
  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam int SW = $clog2(NSLOT);
  localparam logic [6:0] NSLOT7 = 7'(NSLOT);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_FENCE} state_t;

  state_t           r_state, w_state_nxt;
  logic [NSLOT-1:0] r_slot_used;
  logic [IW-1:0]    r_slot_owner [NSLOT];
  logic [6:0]       r_count;
  logic [IW-1:0]    r_ptr, r_drain_idx;
  logic [SW-1:0]    r_fence_slot;
  logic             r_out_valid, r_id_err;

  logic             w_win_any, w_free_any, w_resp_ok, w_space, w_grant, w_drain_set;
  logic [IW-1:0]    w_win_idx, w_gnt_idx;
  logic [SW-1:0]    w_free_idx, w_resp_idx;
  logic [4:0]       w_win_cmd;

  function automatic logic f_is_fence(input logic [4:0] cmd);
    return (cmd == 5'b00101) || (cmd == 5'b10100);
  endfunction

  function automatic logic [IW-1:0] f_next_ptr(input logic [IW-1:0] idx);
    return (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Winner is the first valid requester at or after the round-robin pointer.
  always_comb begin
    w_win_any = 1'b0;
    w_win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_win_any = 1'b1;
        w_win_idx = IW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    w_free_any = 1'b0;
    w_free_idx = '0;
    for (int s = NSLOT - 1; s >= 0; s--) begin
      if (!r_slot_used[s]) begin
        w_free_any = 1'b1;
        w_free_idx = SW'(s);
      end
    end
  end

  assign w_resp_idx = cache_resp_id[SW-1:0];
  assign w_resp_ok  = cache_resp_valid && (cache_resp_id < NSLOT7) && r_slot_used[w_resp_idx];
  assign w_space    = !r_out_valid || cache_req_ready;
  assign w_win_cmd  = req_cmd[w_win_idx*5 +: 5];

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_gnt_idx   = w_win_idx;
    w_drain_set = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_win_any) begin
          if (f_is_fence(w_win_cmd)) begin
            if ((r_count != 7'd0) || r_out_valid) begin
              w_state_nxt = S_DRAIN;
              w_drain_set = 1'b1;
            end else begin
              w_grant     = 1'b1;
              w_state_nxt = S_FENCE;
            end
          end else if (w_free_any && w_space) begin
            w_grant = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // The fence winner captured on entry stays the winner while draining.
        w_gnt_idx = r_drain_idx;
        if (!req_valid[r_drain_idx]) begin
          w_state_nxt = S_RUN;
        end else if ((r_count == 7'd0) && !r_out_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = S_FENCE;
        end
      end
      S_FENCE: begin
        if (w_resp_ok && (w_resp_idx == r_fence_slot)) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
    if (reset) w_grant = 1'b0;
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i]  = w_grant && (w_gnt_idx == IW'(i));
      resp_valid[i] = !reset && w_resp_ok && (r_slot_owner[w_resp_idx] == IW'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_ptr        <= '0;
      r_drain_idx  <= '0;
      r_fence_slot <= '0;
      r_slot_used  <= '0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_id_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_drain_set) r_drain_idx <= w_win_idx;
      if (w_grant) begin
        r_ptr <= f_next_ptr(w_gnt_idx);
        r_slot_used[w_free_idx] <= 1'b1;
        if (w_state_nxt == S_FENCE) r_fence_slot <= w_free_idx;
      end
      if (w_resp_ok) r_slot_used[w_resp_idx] <= 1'b0;
      case ({w_grant, w_resp_ok})
        2'b10:   r_count <= r_count + 7'd1;
        2'b01:   r_count <= r_count - 7'd1;
        default: r_count <= r_count;
      endcase
      if (w_grant) r_out_valid <= 1'b1;
      else if (cache_req_ready) r_out_valid <= 1'b0;
      if (cache_resp_valid && !w_resp_ok) r_id_err <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_grant) r_slot_owner[w_free_idx] <= w_gnt_idx;
  end

  // Output stage: payload and ID held until the cache takes them.
  always_ff @(posedge clock) begin
    if (reset) begin
      cache_req_addr   <= '0;
      cache_req_wmask  <= '0;
      cache_req_wdata  <= '0;
      cache_req_cmd    <= '0;
      cache_req_signed <= 1'b0;
      cache_req_size   <= '0;
      cache_req_id     <= '0;
    end else if (w_grant) begin
      cache_req_addr   <= req_addr[w_gnt_idx*32 +: 32];
      cache_req_wmask  <= req_wmask[w_gnt_idx*4 +: 4];
      cache_req_wdata  <= req_wdata[w_gnt_idx*32 +: 32];
      cache_req_cmd    <= req_cmd[w_gnt_idx*5 +: 5];
      cache_req_signed <= req_signed[w_gnt_idx];
      cache_req_size   <= req_size[w_gnt_idx*2 +: 2];
      cache_req_id     <= 7'(w_free_idx);
    end
  end

  assign cache_req_valid = r_out_valid;
  assign outstanding     = r_count;
  assign id_err          = r_id_err;

`ifdef SIFIVE_DCACHE_ARB_SCOPE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      scope_valid  <= 1'b0;
      scope_addr   <= '0;
      scope_wmask  <= '0;
      scope_wdata  <= '0;
      scope_id     <= '0;
      scope_cmd    <= '0;
      scope_signed <= 1'b0;
      scope_size   <= '0;
    end else begin
      scope_valid <= r_out_valid && cache_req_ready;
      if (r_out_valid && cache_req_ready) begin
        scope_addr   <= cache_req_addr;
        scope_wmask  <= cache_req_wmask;
        scope_wdata  <= cache_req_wdata;
        scope_id     <= cache_req_id;
        scope_cmd    <= cache_req_cmd;
        scope_signed <= cache_req_signed;
        scope_size   <= cache_req_size;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sifive_hart_dcache_req_arbiter.sv
// Bench for sifive_hart_dcache_req_arbiter: vector table for round-robin/response routing,
// a scoreboard on the cache request port, and hand sequences for exhaustion, fence, stall and id_err.
module tb_sifive_hart_dcache_req_arbiter;
  localparam int NREQ  = 2;
  localparam int NSLOT = 8;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_addr;
  logic [NREQ*4-1:0]   req_wmask;
  logic [NREQ*32-1:0]  req_wdata;
  logic [NREQ*5-1:0]   req_cmd;
  logic [NREQ-1:0]     req_signed;
  logic [NREQ*2-1:0]   req_size;
  logic                cache_req_valid;
  logic                cache_req_ready;
  logic [31:0]         cache_req_addr;
  logic [3:0]          cache_req_wmask;
  logic [31:0]         cache_req_wdata;
  logic [4:0]          cache_req_cmd;
  logic                cache_req_signed;
  logic [1:0]          cache_req_size;
  logic [6:0]          cache_req_id;
  logic                cache_resp_valid;
  logic [6:0]          cache_resp_id;
  logic [NREQ-1:0]     resp_valid;
  logic [6:0]          outstanding;
  logic                id_err;
`ifdef SIFIVE_DCACHE_ARB_SCOPE_EN
  logic                scope_valid;
  logic [31:0]         scope_addr;
  logic [3:0]          scope_wmask;
  logic [31:0]         scope_wdata;
  logic [6:0]          scope_id;
  logic [4:0]          scope_cmd;
  logic                scope_signed;
  logic [1:0]          scope_size;
`endif

  sifive_hart_dcache_req_arbiter #(.NREQ(NREQ), .NSLOT(NSLOT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wmask(req_wmask), .req_wdata(req_wdata), .req_cmd(req_cmd),
    .req_signed(req_signed), .req_size(req_size),
    .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready),
    .cache_req_addr(cache_req_addr), .cache_req_wmask(cache_req_wmask),
    .cache_req_wdata(cache_req_wdata), .cache_req_cmd(cache_req_cmd),
    .cache_req_signed(cache_req_signed), .cache_req_size(cache_req_size),
    .cache_req_id(cache_req_id),
    .cache_resp_valid(cache_resp_valid), .cache_resp_id(cache_resp_id),
    .resp_valid(resp_valid), .outstanding(outstanding), .id_err(id_err)
`ifdef SIFIVE_DCACHE_ARB_SCOPE_EN
    ,
    .scope_valid(scope_valid), .scope_addr(scope_addr), .scope_wmask(scope_wmask),
    .scope_wdata(scope_wdata), .scope_id(scope_id), .scope_cmd(scope_cmd),
    .scope_signed(scope_signed), .scope_size(scope_size)
`endif
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  cmd;
    logic [6:0]  id;
  } txn_t;

  typedef struct {
    logic [1:0] vld;
    logic       crdy;
    logic       rv;
    logic [6:0] rid;
    logic [1:0] exp_rdy;
    logic [1:0] exp_resp;
    logic [6:0] exp_out;
  } vec_t;

  txn_t             sb_q[$];
  logic [NSLOT-1:0] tb_used;
  vec_t             tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expected transactions are queued at accept, checked at the cache handshake.
  always @(negedge clock) begin
    txn_t e;
    int   f;
    if (reset) begin
      sb_q.delete();
      tb_used = '0;
    end else begin
      if (cache_req_valid && cache_req_ready) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_unexpected: got id %0d, expected no request", cache_req_id);
        end else begin
          e = sb_q.pop_front();
          chk("sb_addr", cache_req_addr, e.addr);
          chk("sb_id", 32'(cache_req_id), 32'(e.id));
          chk("sb_cmd", 32'(cache_req_cmd), 32'(e.cmd));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          f = -1;
          for (int s = NSLOT - 1; s >= 0; s--) if (!tb_used[s]) f = s;
          if (f < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_alloc: got accept from req %0d, expected none (pool full)", i);
          end else begin
            tb_used[f] = 1'b1;
            e.addr = req_addr[i*32 +: 32];
            e.cmd  = req_cmd[i*5 +: 5];
            e.id   = 7'(f);
            sb_q.push_back(e);
          end
        end
      end
      if (cache_resp_valid && (cache_resp_id < 7'(NSLOT)) && tb_used[cache_resp_id[2:0]])
        tb_used[cache_resp_id[2:0]] = 1'b0;
    end
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid        = '0;
    req_addr         = '0;
    req_wmask        = '0;
    req_wdata        = '0;
    req_cmd          = '0;
    req_signed       = '0;
    req_size         = '0;
    cache_req_ready  = 1'b1;
    cache_resp_valid = 1'b0;
    cache_resp_id    = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [4:0] c);
    req_valid[i]       = v;
    req_addr[i*32 +: 32] = a;
    req_cmd[i*5 +: 5]  = c;
  endtask

  task automatic resp(input logic v, input logic [6:0] id);
    cache_resp_valid = v;
    cache_resp_id    = id;
  endtask

  task automatic do_reset();
    next();
    reset = 1'b1;
    idle_inputs();
    next();
    next();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nrdy;
    tbl[0]  = '{2'b11, 1'b1, 1'b0, 7'd0, 2'b01, 2'b00, 7'd0};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 7'd0, 2'b10, 2'b00, 7'd1};
    tbl[2]  = '{2'b11, 1'b1, 1'b0, 7'd0, 2'b01, 2'b00, 7'd2};
    tbl[3]  = '{2'b11, 1'b1, 1'b0, 7'd0, 2'b10, 2'b00, 7'd3};
    tbl[4]  = '{2'b00, 1'b1, 1'b1, 7'd0, 2'b00, 2'b01, 7'd4};
    tbl[5]  = '{2'b10, 1'b1, 1'b1, 7'd1, 2'b10, 2'b10, 7'd3};
    tbl[6]  = '{2'b01, 1'b1, 1'b1, 7'd2, 2'b01, 2'b01, 7'd3};
    tbl[7]  = '{2'b11, 1'b1, 1'b1, 7'd3, 2'b10, 2'b10, 7'd3};
    tbl[8]  = '{2'b00, 1'b1, 1'b1, 7'd0, 2'b00, 2'b10, 7'd3};
    tbl[9]  = '{2'b00, 1'b1, 1'b1, 7'd1, 2'b00, 2'b01, 7'd2};
    tbl[10] = '{2'b00, 1'b1, 1'b1, 7'd2, 2'b00, 2'b10, 7'd1};

    idle_inputs();
    do_reset();
    #1;
    chk("rst_cache_req_valid", 32'(cache_req_valid), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_id_err", 32'(id_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_cache_req_addr", cache_req_addr, 32'd0);
    chk("rst_cache_req_id", 32'(cache_req_id), 32'd0);

    // Round-robin grants and response routing by owner.
    for (int r = 0; r < 11; r++) begin
      next();
      chk($sformatf("t%0d_outstanding", r), 32'(outstanding), 32'(tbl[r].exp_out));
      for (int i = 0; i < NREQ; i++)
        set_req(i, tbl[r].vld[i], 32'hA000_0000 + 32'(r << 8) + 32'(i * 4), 5'b00000);
      cache_req_ready = tbl[r].crdy;
      resp(tbl[r].rv, tbl[r].rid);
      #1;
      chk($sformatf("t%0d_req_ready", r), 32'(req_ready), 32'(tbl[r].exp_rdy));
      chk($sformatf("t%0d_resp_valid", r), 32'(resp_valid), 32'(tbl[r].exp_resp));
    end
    next();
    idle_inputs();
    #1;
    chk("t_end_outstanding", 32'(outstanding), 32'd0);

    // Slot exhaustion, then reuse of a freed ID from the following cycle.
    do_reset();
    nrdy = 0;
    for (int c = 0; c < 10; c++) begin
      next();
      set_req(0, 1'b1, 32'h1000_0000 + 32'(c * 4), 5'b00000);
      #1;
      if (req_ready[0]) nrdy++;
    end
    chk("full_accepts", 32'(nrdy), 32'd8);
    next();
    resp(1'b1, 7'd3);
    #1;
    chk("full_outstanding", 32'(outstanding), 32'd8);
    chk("full_ready_on_resp", 32'(req_ready), 32'd0);
    chk("full_resp_valid", 32'(resp_valid), 32'b01);
    next();
    resp(1'b0, 7'd0);
    #1;
    chk("full_reuse_ready", 32'(req_ready), 32'b01);
    next();
    set_req(0, 1'b0, 32'h0, 5'b00000);
    #1;
    chk("full_reuse_id", 32'(cache_req_id), 32'd3);
    chk("full_reuse_valid", 32'(cache_req_valid), 32'd1);
    chk("full_reuse_outstanding", 32'(outstanding), 32'd8);

    // Fence drains outstanding loads, then blocks others until its own response.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      next();
      set_req(0, 1'b1, 32'h2000_0000 + 32'(c * 4), 5'b00000);
      #1;
      chk($sformatf("fence_load%0d_ready", c), 32'(req_ready), 32'b01);
    end
    next();
    set_req(0, 1'b1, 32'h2000_0100, 5'b00101);
    #1;
    chk("fence_enter_drain", 32'(req_ready), 32'd0);
    next();
    set_req(1, 1'b1, 32'h2100_0000, 5'b00000);
    #1;
    chk("fence_drain_hold", 32'(req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      next();
      resp(1'b1, 7'(c));
      #1;
      chk($sformatf("fence_drain_resp%0d_ready", c), 32'(req_ready), 32'd0);
      chk($sformatf("fence_drain_resp%0d_owner", c), 32'(resp_valid), 32'b01);
    end
    next();
    resp(1'b0, 7'd0);
    #1;
    chk("fence_grant", 32'(req_ready), 32'b01);
    next();
    set_req(0, 1'b0, 32'h0, 5'b00000);
    #1;
    chk("fence_issued_cmd", 32'(cache_req_cmd), 32'b00101);
    chk("fence_issued_id", 32'(cache_req_id), 32'd0);
    chk("fence_block0", 32'(req_ready), 32'd0);
    next();
    #1;
    chk("fence_block1", 32'(req_ready), 32'd0);
    next();
    resp(1'b1, 7'd0);
    #1;
    chk("fence_resp_block", 32'(req_ready), 32'd0);
    chk("fence_resp_owner", 32'(resp_valid), 32'b01);
    next();
    resp(1'b0, 7'd0);
    #1;
    chk("fence_release", 32'(req_ready), 32'b10);
    next();
    idle_inputs();

    // Backpressure: payload and ID stay put while the cache stalls.
    do_reset();
    nrdy = 0;
    next();
    cache_req_ready = 1'b0;
    set_req(0, 1'b1, 32'h8000_0010, 5'b00000);
    #1;
    if (req_ready[0]) nrdy++;
    chk("stall_first_ready", 32'(req_ready), 32'b01);
    for (int c = 0; c < 5; c++) begin
      next();
      set_req(0, 1'b1, 32'h8000_0020, 5'b00000);
      #1;
      if (req_ready[0]) nrdy++;
      chk($sformatf("stall%0d_valid", c), 32'(cache_req_valid), 32'd1);
      chk($sformatf("stall%0d_addr", c), cache_req_addr, 32'h8000_0010);
      chk($sformatf("stall%0d_id", c), 32'(cache_req_id), 32'd0);
    end
    chk("stall_ready_total", 32'(nrdy), 32'd1);
    next();
    cache_req_ready = 1'b1;
    #1;
    chk("stall_release_ready", 32'(req_ready), 32'b01);
    next();
    set_req(0, 1'b0, 32'h0, 5'b00000);
    #1;
    chk("stall_next_addr", cache_req_addr, 32'h8000_0020);
    chk("stall_next_id", 32'(cache_req_id), 32'd1);
`ifdef SIFIVE_DCACHE_ARB_SCOPE_EN
    chk("scope_valid", 32'(scope_valid), 32'd1);
    chk("scope_addr", scope_addr, 32'h8000_0010);
    chk("scope_id", 32'(scope_id), 32'd0);
`endif
    next();
    #1;

    // Bad response IDs set a sticky error; late responses after reset count as bad.
    do_reset();
    next();
    resp(1'b1, 7'd40);
    #1;
    chk("iderr_no_resp_valid", 32'(resp_valid), 32'd0);
    chk("iderr_before", 32'(id_err), 32'd0);
    next();
    resp(1'b0, 7'd0);
    #1;
    chk("iderr_set", 32'(id_err), 32'd1);
    for (int c = 0; c < 3; c++) next();
    #1;
    chk("iderr_sticky", 32'(id_err), 32'd1);
    do_reset();
    next();
    #1;
    chk("iderr_cleared", 32'(id_err), 32'd0);
    resp(1'b1, 7'd1);
    #1;
    chk("late_resp_no_valid", 32'(resp_valid), 32'd0);
    next();
    resp(1'b0, 7'd0);
    #1;
    chk("late_resp_iderr", 32'(id_err), 32'd1);
    next();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
